queue_enq_arbiter: RTL and testbench

- Shares the single byte-queue enqueue port between two deserializer channels, A and B.
- Each channel presents an assembled byte with a valid level. The arbiter grants one channel per slot, round-robin.
- Issues a one-cycle enqueue pulse to the queue and acks the granted channel.
- Stalls all grants while the queue reports full. Sits between the deserializers and the queue inside top-level integration, on clock_1M.

---
 rtl/queue_enq_arbiter.sv | 127 ++++++++++++
 tb/tb_queue_enq_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/queue_enq_arbiter.sv
// Round-robin arbiter sharing the byte-queue enqueue port between two deserializer channels.
// Optional ARB_FIXED_PRIO_EN: channel A always wins contention and the round-robin pointer is frozen.
//
// state  | meaning
// IDLE   | sample valids and queue occupancy, grant a channel or stall
// ISSUE  | enq/ack pulse for the granted byte, advance pointer, load settle timer
// SETTLE | wait SETTLE_CYCLES for len_in to reflect the new byte
module queue_enq_arbiter #(
  parameter int QUEUE_DEPTH   = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clock_1M,
  input  logic       reset,
  input  logic [7:0] data_a_in,
  input  logic       valid_a_in,
  output logic       ack_a_out,
  input  logic [7:0] data_b_in,
  input  logic       valid_b_in,
  output logic       ack_b_out,
  input  logic [3:0] len_in,
  output logic       enq_out,
  output logic [7:0] enq_data_out,
  output logic [1:0] grant_out,
  output logic       stall_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam logic [4:0] DEPTH_LIM = 5'(QUEUE_DEPTH);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  state_t     state, state_nxt;
  logic       ptr_b, ptr_b_nxt;
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic       ack_a_nxt, ack_b_nxt, enq_nxt, stall_nxt;
  logic [7:0] enq_data_nxt;
  logic [1:0] grant_nxt;
  logic       full, pick_a, pick_b;

  assign full = ({1'b0, len_in} >= DEPTH_LIM);

`ifdef ARB_FIXED_PRIO_EN
  assign pick_a = valid_a_in;
  assign pick_b = valid_b_in & ~valid_a_in;
`else
  assign pick_a = valid_a_in & (~valid_b_in | ~ptr_b);
  assign pick_b = valid_b_in & (~valid_a_in | ptr_b);
`endif

  always_ff @(posedge clock_1M or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr_b        <= 1'b0;
      settle_cnt   <= 4'd0;
      ack_a_out    <= 1'b0;
      ack_b_out    <= 1'b0;
      enq_out      <= 1'b0;
      enq_data_out <= 8'h00;
      grant_out    <= 2'b00;
      stall_out    <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr_b        <= ptr_b_nxt;
      settle_cnt   <= settle_cnt_nxt;
      ack_a_out    <= ack_a_nxt;
      ack_b_out    <= ack_b_nxt;
      enq_out      <= enq_nxt;
      enq_data_out <= enq_data_nxt;
      grant_out    <= grant_nxt;
      stall_out    <= stall_nxt;
    end
  end

  // enq/ack are registered on the grant edge so they are high for exactly the ISSUE cycle
  always_comb begin
    state_nxt      = state;
    ptr_b_nxt      = ptr_b;
    settle_cnt_nxt = settle_cnt;
    ack_a_nxt      = 1'b0;
    ack_b_nxt      = 1'b0;
    enq_nxt        = 1'b0;
    stall_nxt      = 1'b0;
    enq_data_nxt   = enq_data_out;
    grant_nxt      = grant_out;
    case (state)
      IDLE: begin
        stall_nxt = full & (valid_a_in | valid_b_in);
        if (!full) begin
          if (pick_a) begin
            grant_nxt    = 2'b01;
            enq_data_nxt = data_a_in;
            enq_nxt      = 1'b1;
            ack_a_nxt    = 1'b1;
            state_nxt    = ISSUE;
          end else if (pick_b) begin
            grant_nxt    = 2'b10;
            enq_data_nxt = data_b_in;
            enq_nxt      = 1'b1;
            ack_b_nxt    = 1'b1;
            state_nxt    = ISSUE;
          end
        end
      end
      ISSUE: begin
`ifndef ARB_FIXED_PRIO_EN
        ptr_b_nxt = grant_out[0];
`endif
        settle_cnt_nxt = SETTLE_LD;
        state_nxt      = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt <= 4'd1) begin
          settle_cnt_nxt = 4'd0;
          state_nxt      = IDLE;
        end else begin
          settle_cnt_nxt = settle_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_queue_enq_arbiter.sv
// Directed self-checking bench for queue_enq_arbiter (default SETTLE_CYCLES=2, QUEUE_DEPTH=8).
`timescale 1ns/1ps
module tb_queue_enq_arbiter;

  localparam int S = 2;

  logic       clock_1M = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_a_in = 8'h00;
  logic       valid_a_in = 1'b0;
  logic       ack_a_out;
  logic [7:0] data_b_in = 8'h00;
  logic       valid_b_in = 1'b0;
  logic       ack_b_out;
  logic [3:0] len_in = 4'd0;
  logic       enq_out;
  logic [7:0] enq_data_out;
  logic [1:0] grant_out;
  logic       stall_out;

  int n_checks = 0;
  int n_pass = 0;

  queue_enq_arbiter #(.QUEUE_DEPTH(8), .SETTLE_CYCLES(S)) dut (
    .clock_1M(clock_1M), .reset(reset),
    .data_a_in(data_a_in), .valid_a_in(valid_a_in), .ack_a_out(ack_a_out),
    .data_b_in(data_b_in), .valid_b_in(valid_b_in), .ack_b_out(ack_b_out),
    .len_in(len_in), .enq_out(enq_out), .enq_data_out(enq_data_out),
    .grant_out(grant_out), .stall_out(stall_out)
  );

  always #500 clock_1M = ~clock_1M;

  task automatic do_reset();
    @(negedge clock_1M);
    reset = 1'b1; valid_a_in = 1'b0; valid_b_in = 1'b0; len_in = 4'd0;
    @(negedge clock_1M);
    reset = 1'b0;
  endtask

  task automatic wait_enq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_1M);
      if (enq_out === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clock_1M);
    n_checks++;
    if ({enq_out, ack_a_out, ack_b_out, stall_out} !== 4'b0000) $display("FAIL reset_strobes got %b want 0000", {enq_out, ack_a_out, ack_b_out, stall_out});
    else n_pass++;
    n_checks++;
    if (enq_data_out !== 8'h00) $display("FAIL reset_data got %h want 00", enq_data_out);
    else n_pass++;
    n_checks++;
    if (grant_out !== 2'b00) $display("FAIL reset_grant got %b want 00", grant_out);
    else n_pass++;
    reset = 1'b0;
    repeat (3) @(negedge clock_1M);
    n_checks++;
    if ({enq_out, grant_out} !== 3'b000) $display("FAIL idle_quiet got %b want 000", {enq_out, grant_out});
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    data_a_in = 8'hAA; valid_a_in = 1'b1; len_in = 4'd0;
    @(negedge clock_1M);
    n_checks++;
    if ({enq_out, ack_a_out, ack_b_out} !== 3'b110) $display("FAIL single_enq_ack got %b want 110", {enq_out, ack_a_out, ack_b_out});
    else n_pass++;
    n_checks++;
    if (enq_data_out !== 8'hAA) $display("FAIL single_data got %h want aa", enq_data_out);
    else n_pass++;
    n_checks++;
    if (grant_out !== 2'b01) $display("FAIL single_grant got %b want 01", grant_out);
    else n_pass++;
    data_a_in = 8'h5A;
    len_in = 4'd1;
    for (int k = 1; k <= S + 1; k++) begin
      @(negedge clock_1M);
      n_checks++;
      if ({enq_out, ack_a_out} !== 2'b00) $display("FAIL single_gap cycle %0d got %b want 00", k, {enq_out, ack_a_out});
      else n_pass++;
      n_checks++;
      if (grant_out !== 2'b01 || enq_data_out !== 8'hAA) $display("FAIL single_hold cycle %0d got %b/%h want 01/aa", k, grant_out, enq_data_out);
      else n_pass++;
    end
    @(negedge clock_1M);
    n_checks++;
    if ({enq_out, ack_a_out} !== 2'b11 || enq_data_out !== 8'h5A) $display("FAIL single_period got %b/%h want 11/5a", {enq_out, ack_a_out}, enq_data_out);
    else n_pass++;
    valid_a_in = 1'b0;
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [1:0] exp_g;
    do_reset();
    data_a_in = 8'h55; data_b_in = 8'hCC; valid_a_in = 1'b1; valid_b_in = 1'b1; len_in = 4'd0;
    for (int slot = 0; slot < 4; slot++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (slot % 2 == 0) ? 2'b01 : 2'b10;
`endif
      wait_enq(ok);
      n_checks++;
      if (!ok) $display("FAIL sim_timeout slot %0d got no enq want enq", slot);
      else n_pass++;
      n_checks++;
      if (grant_out !== exp_g) $display("FAIL sim_grant slot %0d got %b want %b", slot, grant_out, exp_g);
      else n_pass++;
      n_checks++;
      if (enq_data_out !== ((exp_g == 2'b01) ? 8'h55 : 8'hCC)) $display("FAIL sim_data slot %0d got %h want %h", slot, enq_data_out, (exp_g == 2'b01) ? 8'h55 : 8'hCC);
      else n_pass++;
      n_checks++;
      if ({ack_b_out, ack_a_out} !== exp_g) $display("FAIL sim_ack slot %0d got %b want %b", slot, {ack_b_out, ack_a_out}, exp_g);
      else n_pass++;
      len_in = len_in + 4'd1;
    end
    valid_a_in = 1'b0; valid_b_in = 1'b0;
  endtask

  task automatic test_full_stall();
    int bad_enq = 0;
    int bad_stall = 0;
    do_reset();
    len_in = 4'd8; data_b_in = 8'h33; valid_b_in = 1'b1;
    @(negedge clock_1M);
    n_checks++;
    if (stall_out !== 1'b1) $display("FAIL stall_assert got %b want 1", stall_out);
    else n_pass++;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock_1M);
      if (enq_out !== 1'b0 || ack_a_out !== 1'b0 || ack_b_out !== 1'b0) bad_enq++;
      if (stall_out !== 1'b1) bad_stall++;
    end
    n_checks++;
    if (bad_enq != 0) $display("FAIL stall_no_enq got %0d strobe cycles want 0", bad_enq);
    else n_pass++;
    n_checks++;
    if (bad_stall != 0) $display("FAIL stall_held got %0d low cycles want 0", bad_stall);
    else n_pass++;
    len_in = 4'd7;
    @(negedge clock_1M);
    n_checks++;
    if ({stall_out, enq_out, ack_b_out, ack_a_out} !== 4'b0110) $display("FAIL stall_release got %b want 0110", {stall_out, enq_out, ack_b_out, ack_a_out});
    else n_pass++;
    n_checks++;
    if (enq_data_out !== 8'h33 || grant_out !== 2'b10) $display("FAIL stall_release_data got %h/%b want 33/10", enq_data_out, grant_out);
    else n_pass++;
    valid_b_in = 1'b0; len_in = 4'd0;
  endtask

  task automatic test_withdrawal();
    bit ok;
    int bad = 0;
    do_reset();
    data_a_in = 8'hA5; data_b_in = 8'h77; valid_b_in = 1'b1;
    wait_enq(ok);
    n_checks++;
    if (!ok || ack_b_out !== 1'b1 || enq_data_out !== 8'h77) $display("FAIL wd_b_slot got ok=%0d ack_b=%b data=%h want 1/1/77", ok, ack_b_out, enq_data_out);
    else n_pass++;
    valid_b_in = 1'b0;
    @(negedge clock_1M);
    valid_a_in = 1'b1;
    @(negedge clock_1M);
    valid_a_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock_1M);
      if (enq_out !== 1'b0 || ack_a_out !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL wd_no_enq got %0d strobe cycles want 0", bad);
    else n_pass++;
    n_checks++;
    if (grant_out !== 2'b10) $display("FAIL wd_grant_hold got %b want 10", grant_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    data_a_in = 8'h55; data_b_in = 8'hCC; valid_a_in = 1'b1; valid_b_in = 1'b1; len_in = 4'd0;
    wait_enq(ok);
    n_checks++;
    if (!ok || grant_out !== 2'b01) $display("FAIL rm_first got ok=%0d grant=%b want 1/01", ok, grant_out);
    else n_pass++;
    wait_enq(ok);
    n_checks++;
`ifdef ARB_FIXED_PRIO_EN
    if (!ok || grant_out !== 2'b01) $display("FAIL rm_second got ok=%0d grant=%b want 1/01", ok, grant_out);
`else
    if (!ok || grant_out !== 2'b10) $display("FAIL rm_second got ok=%0d grant=%b want 1/10", ok, grant_out);
`endif
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({enq_out, ack_a_out, ack_b_out, grant_out} !== 5'b00000) $display("FAIL rm_clear got %b want 00000", {enq_out, ack_a_out, ack_b_out, grant_out});
    else n_pass++;
    n_checks++;
    if (enq_data_out !== 8'h00) $display("FAIL rm_data got %h want 00", enq_data_out);
    else n_pass++;
    @(negedge clock_1M);
    reset = 1'b0;
    @(negedge clock_1M);
    n_checks++;
    if ({enq_out, ack_a_out, ack_b_out, grant_out} !== 5'b11001) $display("FAIL rm_after got %b want 11001", {enq_out, ack_a_out, ack_b_out, grant_out});
    else n_pass++;
    valid_a_in = 1'b0; valid_b_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_full_stall();
    test_withdrawal();
    test_reset_mid();
    repeat (2) @(negedge clock_1M);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
